// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter:
// requester count, index width, FSM states and the default hold limit.
package rr_arb_pkg;

    localparam int NREQ         = 8;
    localparam int IDW          = 3;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master: requester side (drives req/done); slave: arbiter side.
interface rr_arb_if;
    import rr_arb_pkg::*;

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/decoder_3to8.sv
// Plain 3-to-8 one-hot decoder.
module decoder_3to8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    assign y = 8'b0000_0001 << a;

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping modulo 8. any=0 when no request is pending.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] k;

    // Walk the eight positions starting at ptr; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        k   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            k = ptr + IDW'(i);
            if (!any && req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a two-state IDLE/GRANT FSM.
// A grant is held until done or until the owner withdraws its request;
// every release is followed by one IDLE cycle before the next grant.
// Optional feature macro ARB_TIMEOUT_EN: a 4-bit hold counter forces a
// release after MAX_HOLD grant cycles and pulses timeout for one cycle.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    rr_arb_if.slave bus
);

    // The hold limit must fit the 4-bit counter and be non-zero.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 1..15");
    end

    arb_state_e      state, state_n;
    logic [IDW-1:0]  ptr, ptr_n;
    logic [IDW-1:0]  gnt_id, gnt_id_n;
    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] dec;
    logic            owner_release;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
    logic [3:0] hold_cnt, hold_cnt_n;
    logic       timeout_q, timeout_n;
`endif

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    decoder_3to8 u_dec (
        .a (gnt_id),
        .y (dec)
    );

    // Owner gives up the resource by pulsing done or dropping its request.
    assign owner_release = bus.done || !bus.req[gnt_id];

    // Next-state, next-owner and pointer update.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_id_n = gnt_id;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n  = GRANT;
                    gnt_id_n = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end
            end
            GRANT: begin
                if (owner_release) begin
                    state_n = IDLE;
                    ptr_n   = gnt_id + 3'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt + 4'd1 == HOLD_LIM) begin
                    // Limit reached with no voluntary release: force one.
                    state_n   = IDLE;
                    ptr_n     = gnt_id + 3'd1;
                    timeout_n = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + 4'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointer and owner registers; reset restarts the search at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt_id <= gnt_id_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and registered one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt_valid = (state == GRANT);
    assign bus.gnt_id    = gnt_id;
    assign bus.gnt       = dec & {NREQ{bus.gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus random traffic,
// checked against a behavioural round-robin model (owner/pointer as ints).
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference model state.
    int   m_owner;   // -1 when nobody holds the grant
    int   m_ptr;
    int   m_gid;
    int   m_held;
    bit   m_to;

    rr_arb_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_gid   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the arbiter's rules applied to sampled req/done.
    task automatic model_step(input logic [7:0] r, input logic d);
        bit rel;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int j = 0; j < 8; j++) begin
                int k;
                k = (m_ptr + j) % 8;
                if (m_owner < 0 && r[k]) begin
                    m_owner = k;
                    m_gid   = k;
                    m_held  = 0;
                end
            end
        end else begin
            m_held = m_held + 1;
            rel = d || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (!rel && m_held >= MAXH) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end
`endif
            if (rel) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        chk({tag, "_gnt"},   32'(bus.gnt),       32'(eg));
        chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
        chk({tag, "_id"},    32'(bus.gnt_id),    32'(m_gid));
        chk({tag, "_to"},    32'(bus.timeout),   32'(m_to));
    endtask

    task automatic cycle(input string tag, input logic [7:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_model(tag);
    endtask

    // gnt is one-hot or zero and matches the decode of gnt_id in every cycle.
    always @(negedge clk) begin
        n_cmp++;
        assert ($onehot0(bus.gnt)) else begin
            n_err++;
            $error("FAIL onehot0: observed %0h expected one-hot-or-zero", bus.gnt);
        end
        chk("gnt_decode", 32'(bus.gnt),
            bus.gnt_valid ? 32'(8'd1 << bus.gnt_id) : 32'd0);
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        model_reset();

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model("reset");
        #2 rst_n = 1'b1;

        // 0x81 from ptr=0: owner 0, then 7 after one idle cycle.
        cycle("r81_a", 8'h81, 1'b0);
        chk("r81_first_gnt", 32'(bus.gnt), 32'h01);
        chk("r81_first_id",  32'(bus.gnt_id), 32'd0);
        cycle("r81_rel", 8'h81, 1'b1);
        chk("r81_gap", 32'(bus.gnt_valid), 32'd0);
        cycle("r81_b", 8'h81, 1'b0);
        chk("r81_second_gnt", 32'(bus.gnt), 32'h80);
        cycle("r81_rel2", 8'h81, 1'b1);

        // All requesting with done each grant: order 0..7,0 with 1-cycle gaps.
        for (int g = 0; g < 9; g++) begin
            cycle("ff_gnt", 8'hFF, 1'b0);
            chk("ff_order", 32'(bus.gnt_id), 32'(g % 8));
            cycle("ff_rel", 8'hFF, 1'b1);
            chk("ff_gap", 32'(bus.gnt_valid), 32'd0);
        end

        // Owner 3 withdraws; pointer moves to 4, then 0x09 wraps to 0.
        cycle("w_gnt3", 8'h08, 1'b0);
        chk("w_owner3", 32'(bus.gnt_id), 32'd3);
        cycle("w_drop", 8'h00, 1'b0);
        chk("w_released", 32'(bus.gnt_valid), 32'd0);
        cycle("w_wrap", 8'h09, 1'b0);
        chk("w_wrap_id", 32'(bus.gnt_id), 32'd0);
        cycle("w_rel", 8'h09, 1'b1);

        // done while idle does nothing.
        cycle("idle_done", 8'h00, 1'b1);
        cycle("idle_done2", 8'h00, 1'b0);

        // Owner never releases: held forever, or forced out every MAXH cycles.
        for (int c = 0; c < 110; c++) begin
            cycle("hold", 8'h04, 1'b0);
        end
`ifndef ARB_TIMEOUT_EN
        chk("hold_still_valid", 32'(bus.gnt_valid), 32'd1);
        chk("hold_no_timeout",  32'(bus.timeout),   32'd0);
`endif
        cycle("hold_rel", 8'h04, 1'b1);
        cycle("hold_idle", 8'h00, 1'b0);

        // Asynchronous reset while owner 5 holds the grant.
        cycle("rst_gnt5", 8'h20, 1'b0);
        chk("rst_pre_gnt", 32'(bus.gnt), 32'h20);
        bus.req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_gnt", 32'(bus.gnt), 32'h00);
        check_model("rst_async");
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle("rst_after", 8'h60, 1'b0);
        chk("rst_after_id", 32'(bus.gnt_id), 32'd5);
        cycle("rst_after_rel", 8'h60, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [7:0] r;
            logic       d;
            r = 8'($urandom);
            if ($urandom_range(3) == 0) r = 8'h00;
            d = ($urandom_range(3) == 0);
            cycle("rand", r, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: MAX_HOLD, 15, maximum grant-hold cycles before a forced release (4-bit range 1..15; used only with ARB_TIMEOUT_EN).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  8  per-requester request level; bit i = requester i.
REQ-006 Port: done  input  1  pulse from the current owner releasing the resource; ignored while gnt_valid=0.
REQ-007 Port: gnt  output  8  one-hot grant, equal to the decode of gnt_id when gnt_valid=1; 8'h00 otherwise.
REQ-008 Port: gnt_id  output  3  binary index of the current owner.
REQ-009 Port: gnt_valid  output  1  a grant is held.
REQ-010 Port: timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and GRANT (owner held).
REQ-012 In IDLE with req!=0, the block SHALL select the first set req bit searching upward from ptr, modulo 8.
REQ-013 On that select, the block SHALL register the winner into gnt_id, set gnt_valid=1 and enter GRANT; gnt SHALL be visible on the next edge (1-cycle latency from req sampled in IDLE).
REQ-014 In IDLE with req==0, outputs SHALL hold gnt_valid=0 and gnt=8'h00; gnt_id and ptr SHALL remain unchanged.
REQ-015 In GRANT, the block SHALL release when done=1 or req[gnt_id]=0 (requester withdrawal).
REQ-016 On release, the block SHALL set ptr <= gnt_id+1 (3-bit wrap, 7->0), clear gnt_valid and return to IDLE.
REQ-017 A release SHALL always be followed by exactly one IDLE cycle, so back-to-back grants are 2 cycles apart.
REQ-018 Requests from non-owners during GRANT SHALL NOT affect gnt or gnt_id.
REQ-019 If done and a new request arrive in the same cycle, the release SHALL take effect and the new request SHALL be arbitrated in the following IDLE cycle.
REQ-020 gnt SHALL be one-hot or zero in every cycle; more than one bit set is an error.

Reset
REQ-021 While rst_n=0, asynchronously: state=IDLE, ptr=0, gnt_id=0, gnt_valid=0, gnt=8'h00, timeout=0, hold counter=0.
REQ-022 Reset asserted mid-GRANT SHALL drop the grant immediately with no timeout pulse; after deassertion, the first arbitration SHALL start from ptr=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: a 4-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD without a release, the block SHALL force a release per REQ-016 and pulse timeout=1 for one cycle. If done occurs in the same cycle, it is a normal release and timeout SHALL stay 0.
REQ-025 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter, timeout SHALL be tied 0 and grants SHALL be held indefinitely.

Structure
REQ-026 Package rr_arb_pkg SHALL hold NREQ=8, IDW=3, the state enum {IDLE, GRANT} and the default MAX_HOLD.
REQ-027 The round-robin search SHALL live in sub-module rr_pick8 (combinational; inputs req, ptr; outputs any, idx).
REQ-028 gnt SHALL be produced by instantiating the team's decoder_3to8 on gnt_id, gated by gnt_valid.

Verification
REQ-029 Reset, then req=8'h81 -> the cycle after, gnt=8'h01 and gnt_id=0; done -> 1 idle cycle -> gnt=8'h80.
REQ-030 req=8'hFF held, with done each grant -> grant order 0,1,2,...,7,0; gnt_valid low for 1 cycle between grants.
REQ-031 Owner 3 drops req[3] without done -> release next edge; ptr=4; with req=8'h09 the next grant is 0 (wrap from 4).
REQ-032 ARB_TIMEOUT_EN, MAX_HOLD=4, owner never releases -> forced release after 4 GRANT cycles, timeout=1 for exactly 1 cycle; without the macro the grant holds 100+ cycles and timeout stays 0.
REQ-033 rst_n pulsed low while gnt=8'h20 -> gnt=8'h00 asynchronously; after release, req=8'h60 -> grant 5 (ptr restarted at 0).
REQ-034 done pulsed in IDLE -> no state change; a one-hot-or-zero assertion on gnt SHALL hold for all tests.
